// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: controller state codes shared with the FSM, plus a width helper
package ctrl_seq_pkg;
  typedef enum logic [2:0] {
    ST_ALLOC, ST_LOAD_AND_INIT, ST_CONVOLUTION, ST_LOAD_RESULT,
    ST_LOAD_ERROR, ST_LOAD_OUTPUT, ST_LOAD_INPUT, ST_PC_INCREMENT
  } state_e;
  function automatic int clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: FSM-side controls and sequencer-side flags, addresses and strobes
interface ctrl_seq_if import ctrl_seq_pkg::*; #(
  parameter int NSTAGES = 4,
  parameter int NVECTORS = 2,
  parameter int ADDR_W = 8
) ();
  logic en;
  logic [2:0] state;
  logic vector_pass, last_stage, last_vector;
  logic [clog2(NSTAGES)-1:0] stage_idx;
  logic [clog2(NVECTORS)-1:0] vector_idx;
  logic [ADDR_W-1:0] coef_addr, data_addr;
  logic data_we, mac_clr, mac_acc, err;
  modport master (
    output en, state,
    input vector_pass, last_stage, last_vector, stage_idx, vector_idx,
    input coef_addr, data_addr, data_we, mac_clr, mac_acc, err
  );
  modport slave (
    input en, state,
    output vector_pass, last_stage, last_vector, stage_idx, vector_idx,
    output coef_addr, data_addr, data_we, mac_clr, mac_acc, err
  );
endinterface

// File: rtl/ctrl_seq_ring.sv
// ctrl_seq_ring: per-stage circular history heads and modulo-TAPS sample addresses
module ctrl_seq_ring import ctrl_seq_pkg::*; #(
  parameter int NSTAGES = 4,
  parameter int TAPS = 16,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       inc_i,
  input  logic [clog2(NSTAGES)-1:0]  stage_i,
  input  logic [clog2(TAPS)-1:0]     tap_i,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic [ADDR_W-1:0]          rd_addr_o
);
  localparam int TW = clog2(TAPS);
  logic [TW-1:0] head_q [NSTAGES];
  logic [TW-1:0] head_d [NSTAGES];
  logic [TW-1:0] cur, nxt, diff;
  // TW-bit arithmetic gives the mod-TAPS wrap for free
  always_comb begin
    cur = head_q[stage_i];
    nxt = inc_i ? cur + 1'b1 : cur;
    diff = cur - tap_i;
    head_d = head_q;
    head_d[stage_i] = nxt;
    wr_addr_o = ADDR_W'(int'(stage_i) * TAPS + int'(nxt));
    rd_addr_o = ADDR_W'(int'(stage_i) * TAPS + int'(diff));
  end
  always_ff @(posedge clk) begin
    if (rst) head_q <= '{default: '0};
    else if (en_i) head_q <= head_d;
  end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: tap/stage/vector sequencer driving loop flags, RAM addresses and MAC strobes
// Define CTRL_SEQ_ERR_EN to build the sticky sequencing-error checker.
module ctrl_seq import ctrl_seq_pkg::*; #(
  parameter int NSTAGES = 4,
  parameter int NVECTORS = 2,
  parameter int TAPS = 16,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst,
  ctrl_seq_if.slave bus
);
  localparam int SW = clog2(NSTAGES);
  localparam int VW = clog2(NVECTORS);
  localparam int TW = clog2(TAPS);
  logic [TW-1:0] tap_q, tap_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [VW-1:0] vector_q, vector_d;
  logic init, conv, pc, ls, lv, vp;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  always_comb begin
    init = bus.state == ST_LOAD_AND_INIT;
    conv = bus.state == ST_CONVOLUTION;
    pc = bus.state == ST_PC_INCREMENT;
    ls = stage_q == SW'(NSTAGES - 1);
    lv = vector_q == VW'(NVECTORS - 1);
    vp = conv && tap_q == TW'(TAPS - 1);
    tap_d = init ? '0 : (conv && !vp) ? tap_q + 1'b1 : tap_q;
    stage_d = pc ? (ls ? '0 : stage_q + 1'b1) : stage_q;
    vector_d = (pc && ls) ? (lv ? '0 : vector_q + 1'b1) : vector_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q <= '0;
      stage_q <= '0;
      vector_q <= '0;
    end else if (bus.en) begin
      tap_q <= tap_d;
      stage_q <= stage_d;
      vector_q <= vector_d;
    end
  end
  ctrl_seq_ring #(.NSTAGES(NSTAGES), .TAPS(TAPS), .ADDR_W(ADDR_W)) u_ring (
    .clk(clk),
    .rst(rst),
    .en_i(bus.en),
    .inc_i(init && vector_q == '0),
    .stage_i(stage_q),
    .tap_i(tap_q),
    .wr_addr_o(wr_addr),
    .rd_addr_o(rd_addr)
  );
  assign bus.vector_pass = vp;
  assign bus.last_stage = ls;
  assign bus.last_vector = lv;
  assign bus.stage_idx = stage_q;
  assign bus.vector_idx = vector_q;
  assign bus.coef_addr = ADDR_W'((int'(stage_q) * NVECTORS + int'(vector_q)) * TAPS + int'(tap_q));
  assign bus.data_addr = init ? wr_addr : rd_addr;
  assign bus.data_we = init;
  assign bus.mac_clr = init;
  assign bus.mac_acc = conv;
`ifdef CTRL_SEQ_ERR_EN
  logic [2:0] prev_q;
  logic pvp_q, err_q, err_d;
  // previous-cycle state and vector_pass identify entry to and exit from CONVOLUTION
  always_comb err_d = err_q
      | (conv && prev_q != ST_CONVOLUTION && prev_q != ST_LOAD_AND_INIT)
      | (prev_q == ST_CONVOLUTION && !conv && !pvp_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= ST_ALLOC;
      pvp_q <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.en) begin
      prev_q <= bus.state;
      pvp_q <= vp;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed loops plus random state/en/rst traffic against a counter-level model
module tb_ctrl_seq;
  localparam int NS = 2, NV = 2, T = 4, AW = 8;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_pass = 0;
  int m_tap, m_stg, m_vec, m_err, m_pst, m_pvp;
  int m_head [NS];
  ctrl_seq_if #(.NSTAGES(NS), .NVECTORS(NV), .ADDR_W(AW)) bus ();
  ctrl_seq #(.NSTAGES(NS), .NVECTORS(NV), .TAPS(T), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    m_tap = 0; m_stg = 0; m_vec = 0; m_err = 0; m_pst = 0; m_pvp = 0;
    foreach (m_head[i]) m_head[i] = 0;
  endtask
  task automatic step(input int st, input bit e, input bit r);
    int vp;
    bus.state = 3'(st);
    bus.en = e;
    rst = r;
    #1;
    vp = (st == 2 && m_tap == T - 1) ? 1 : 0;
    chk("vector_pass", 32'(bus.vector_pass), 32'(vp));
    chk("last_stage", 32'(bus.last_stage), 32'(m_stg == NS - 1));
    chk("last_vector", 32'(bus.last_vector), 32'(m_vec == NV - 1));
    chk("stage_idx", 32'(bus.stage_idx), 32'(m_stg));
    chk("vector_idx", 32'(bus.vector_idx), 32'(m_vec));
    chk("coef_addr", 32'(bus.coef_addr), 32'((m_stg * NV + m_vec) * T + m_tap));
    if (st == 1) chk("init_addr", 32'(bus.data_addr), 32'(m_stg * T + (m_head[m_stg] + (m_vec == 0 ? 1 : 0)) % T));
    if (st == 2) chk("conv_addr", 32'(bus.data_addr), 32'(m_stg * T + (m_head[m_stg] - m_tap + T) % T));
    chk("data_we", 32'(bus.data_we), 32'(st == 1));
    chk("mac_clr", 32'(bus.mac_clr), 32'(st == 1));
    chk("mac_acc", 32'(bus.mac_acc), 32'(st == 2));
    chk("err", 32'(bus.err), 32'(m_err));
    @(posedge clk);
    if (r) model_reset();
    else if (e) begin
`ifdef CTRL_SEQ_ERR_EN
      if ((st == 2 && m_pst != 2 && m_pst != 1) || (m_pst == 2 && st != 2 && m_pvp == 0)) m_err = 1;
`endif
      m_pst = st;
      m_pvp = vp;
      if (st == 1) begin
        m_tap = 0;
        if (m_vec == 0) m_head[m_stg] = (m_head[m_stg] + 1) % T;
      end else if (st == 2) m_tap = (m_tap < T - 1) ? m_tap + 1 : m_tap;
      else if (st == 7) begin
        if (m_stg != NS - 1) m_stg++;
        else begin
          m_stg = 0;
          m_vec = (m_vec == NV - 1) ? 0 : m_vec + 1;
        end
      end
    end
    @(negedge clk);
  endtask
  initial begin
    bus.state = 3'd0;
    bus.en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step(0, 1, 0);
    repeat (4) step(2, 1, 0);
    step(3, 1, 1);
    step(1, 1, 0);
    repeat (4) step(2, 1, 0);
    step(3, 1, 0); step(4, 1, 0); step(7, 1, 0);
    step(1, 1, 0);
    repeat (4) step(2, 1, 0);
    step(3, 1, 0); step(7, 1, 0);
    step(1, 1, 0); step(7, 1, 0); step(7, 1, 0); step(0, 1, 0);
    step(0, 1, 1);
    step(1, 1, 0); step(1, 1, 0);
    repeat (5) step(2, 1, 0);
    step(1, 1, 0);
    repeat (2) step(2, 1, 0);
    repeat (3) step(2, 0, 0);
    step(2, 1, 1);
    step(2, 1, 0);
    step(2, 1, 0); step(2, 1, 0); step(3, 1, 0); step(3, 1, 0);
    step(0, 1, 1);
    for (int k = 0; k < 800; k++)
      step(int'($urandom_range(0, 7)), $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Index sequencer for the upsampler controller. It tracks the current FSM state code and keeps the tap, stage and vector counters, plus the per-stage circular history pointers. From these it drives the three loop-exit flags the controller FSM branches on (vector_pass, last_stage, last_vector). It also drives the coefficient/data RAM addresses and the MAC control strobes. It sits between the controller FSM and the MAC/RAM datapath.

## Interface
Parameters:
- NSTAGES, 4, number of upsampler stages (≥1)
- NVECTORS, 2, polyphase vectors per stage (≥1)
- TAPS, 16, MAC taps per vector, power of two (≥2)
- ADDR_W, 8, RAM address width; must hold NSTAGES·NVECTORS·TAPS coefficients and NSTAGES·TAPS samples

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  clock enable; all state updates are gated by en
- state  in  3  current controller FSM state code
- vector_pass  out  1  last tap of the current vector is being issued
- last_stage  out  1  stage_idx == NSTAGES-1
- last_vector  out  1  vector_idx == NVECTORS-1
- stage_idx  out  clog2(NSTAGES)  current stage
- vector_idx  out  clog2(NVECTORS)  current vector
- coef_addr  out  ADDR_W  coefficient RAM read address
- data_addr  out  ADDR_W  sample RAM read/write address
- data_we  out  1  sample RAM write strobe
- mac_clr  out  1  clear MAC accumulator
- mac_acc  out  1  MAC accumulate enable
- err  out  1  sticky sequencing error (see Configuration)

## Operation
- The state codes are 0 ALLOC, 1 LOAD_AND_INIT, 2 CONVOLUTION, 3 LOAD_RESULT, 4 LOAD_ERROR, 5 LOAD_OUTPUT, 6 LOAD_INPUT, 7 PC_INCREMENT.
- Registers: tap_cnt[clog2(TAPS)], stage_idx, vector_idx, and head[NSTAGES] of clog2(TAPS) bits each.
- Reset: all registers are 0 and err is 0. All outputs follow from these registers, so at reset coef_addr = data_addr = 0 and last_stage/last_vector are 1 only if the corresponding parameter equals 1.
- LOAD_AND_INIT:
  - tap_cnt←0 and mac_clr=1.
  - If vector_idx==0, head[stage]←head[stage]+1 (mod TAPS).
  - data_we=1 and data_addr = stage·TAPS + new head.
- CONVOLUTION:
  - mac_acc=1.
  - coef_addr = (stage·NVECTORS + vector)·TAPS + tap_cnt.
  - data_addr = stage·TAPS + ((head[stage] − tap_cnt) mod TAPS).
  - tap_cnt increments each en cycle and saturates at TAPS-1.
  - vector_pass = (state==CONVOLUTION) && (tap_cnt==TAPS-1).
- PC_INCREMENT (en high), counter advance:
  - If !last_stage: stage_idx++.
  - Otherwise stage_idx←0, and vector_idx←last_vector ? 0 : vector_idx+1.
- ALLOC, LOAD_RESULT, LOAD_ERROR, LOAD_OUTPUT, LOAD_INPUT: all counters hold; data_we, mac_clr and mac_acc are 0.
- Address arithmetic is unsigned. Circular wrap uses the low clog2(TAPS) bits only; no divider is used.

## Timing
- All outputs are combinational from registered counters and the state input. There are no registered outputs.
- Zero latency from the state input to the strobes and addresses.
- A counter update is visible the cycle after the enabling edge.
- en low freezes all registers; outputs still track the state input.
- vector_pass is high for exactly the final tap cycle. If the FSM stays in CONVOLUTION longer, vector_pass stays high and tap_cnt holds.
- rst wins over en. rst in mid-convolution returns all counters to 0 on the next edge.
- A PC_INCREMENT with both last flags high wraps stage and vector to 0 in the same edge.

## Configuration
- CTRL_SEQ_ERR_EN defined: err is set (sticky until rst) on either of two events:
  - CONVOLUTION entered without a preceding LOAD_AND_INIT;
  - state leaves CONVOLUTION while vector_pass is 0.
- CTRL_SEQ_ERR_EN undefined: err is tied to 0 and the checker logic is absent.

## Structure
- Shared package holds the 3-bit state code constants, shared with the controller FSM, and a clog2 helper.
- One sub-module, ctrl_seq_ring: the per-stage head pointer array with modulo-TAPS address generation.

## Test plan
All with NSTAGES=2, NVECTORS=2, TAPS=4.
- Reset, then state=2 for 4 cycles -> coef_addr 0,1,2,3; vector_pass only on the 4th cycle; mac_acc=1 throughout.
- Full loop (states 1→2×4→3→4→7) with stage=0 -> stage_idx becomes 1 and last_stage=1; the next PC_INCREMENT gives stage 0 and vector 1.
- Two samples into stage 0, then convolve -> data_addr sequence 2,1,0,3, showing circular wrap.
- PC_INCREMENT with stage=1 and vector=1 -> both indices 0 next cycle and last_vector=0.
- en=0 during CONVOLUTION -> tap_cnt frozen and coef_addr constant; rst asserted mid-vector -> all counters 0 next cycle.
- With CTRL_SEQ_ERR_EN: state 2→3 after 2 taps -> err=1 and held until rst.
